// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the size/legality decode applied to every incoming request.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    FIN  = 2'd3
  } state_e;

  // size is the access width in bytes (1, 2 or 4)
  typedef struct packed {
    logic       err;
    logic [2:0] size;
  } dec_t;

  // Byte count comes from funct3[1:0]; legality depends on load vs store,
  // since the unsigned variants only make sense for loads.
  function automatic dec_t decode(input logic [2:0] f3, input logic wren);
    dec_t d;
    case (f3[1:0])
      2'b00:   d.size = 3'd1;
      2'b01:   d.size = 3'd2;
      default: d.size = 3'd4;
    endcase
    if (wren) begin
      d.err = !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
    end else begin
      d.err = !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                (f3 == F3_BU) || (f3 == F3_HU));
    end
    return d;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit. Stores are spread
// over a 64-bit (two-word) window; loads are pulled out of a two-word window
// and extended according to funct3.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_off_i,
  input  logic [2:0]  st_size_i,
  input  logic [31:0] st_wdata_i,
  output logic [63:0] st_data_o,
  output logic [7:0]  st_mask_o,
  input  logic [1:0]  ld_off_i,
  input  logic [2:0]  ld_f3_i,
  input  logic [31:0] ld_lo_i,
  input  logic [31:0] ld_hi_i,
  output logic [31:0] ld_data_o
);

  logic [3:0]  lane_m;
  logic [31:0] ld_word;

  // Store: mask of s ones and the data, both shifted up by the byte offset
  always_comb begin
    case (st_size_i)
      3'd1:    lane_m = 4'b0001;
      3'd2:    lane_m = 4'b0011;
      default: lane_m = 4'b1111;
    endcase
    st_mask_o = {4'b0000, lane_m} << st_off_i;
    st_data_o = {32'h0000_0000, st_wdata_i} << {st_off_i, 3'b000};
  end

  // Load: shift the {hi, lo} pair down by the offset, then truncate/extend
  always_comb begin
    ld_word = 32'({ld_hi_i, ld_lo_i} >> {ld_off_i, 3'b000});
    case (ld_f3_i)
      F3_B:    ld_data_o = {{24{ld_word[7]}}, ld_word[7:0]};
      F3_BU:   ld_data_o = {24'h00_0000, ld_word[7:0]};
      F3_H:    ld_data_o = {{16{ld_word[15]}}, ld_word[15:0]};
      F3_HU:   ld_data_o = {16'h0000, ld_word[15:0]};
      default: ld_data_o = ld_word;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one request per handshake, issues one or two
// word-aligned memory cycles (two when the access straddles a word
// boundary) and returns a registered one-cycle response.
module lsu
  import lsu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic        i_req_wren,
  input  logic [2:0]  i_req_funct3,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  output logic        o_mem_wren,
  input  logic [31:0] i_mem_rdata
);

  state_e      state_q, state_d;
  dec_t        dec;
  logic        accept;
  logic        split_req;

  // Request context captured at accept
  logic        wren_q, split_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [31:0] st_hi_q;
  logic [3:0]  mask_hi_q;
  logic [31:0] lo_word_q;

  logic [63:0] st_data;
  logic [7:0]  st_mask;
  logic [31:0] ld_lo;
  logic [31:0] ld_data;

  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_bmask_q, mem_bmask_d;
  logic        mem_wren_q, mem_wren_d;

  assign o_req_ready = (state_q == IDLE);
  assign accept      = i_req_valid & o_req_ready;
  assign dec         = decode(i_req_funct3, i_req_wren);
  // Offset plus size past 4 bytes means the access spills into the next word
  assign split_req   = ({2'b00, i_req_addr[1:0]} + {1'b0, dec.size}) > 4'd4;
  // An aligned load has only one word, which arrives in FIN
  assign ld_lo       = split_q ? lo_word_q : i_mem_rdata;

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_bmask = mem_bmask_q;
  assign o_mem_wren  = mem_wren_q;

  lsu_align u_align (
    .st_off_i   (i_req_addr[1:0]),
    .st_size_i  (dec.size),
    .st_wdata_i (i_req_wdata),
    .st_data_o  (st_data),
    .st_mask_o  (st_mask),
    .ld_off_i   (off_q),
    .ld_f3_i    (f3_q),
    .ld_lo_i    (ld_lo),
    .ld_hi_i    (i_mem_rdata),
    .ld_data_o  (ld_data)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: errors never leave IDLE; stores end after their last write
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && !dec.err) state_d = LO;
      LO: begin
        if (split_q)     state_d = HI;
        else if (wren_q) state_d = IDLE;
        else             state_d = FIN;
      end
      HI:      state_d = wren_q ? IDLE : FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next-state: memory cycle for the state being entered, and the response
  always_comb begin
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_addr_d  = 32'h0000_0000;
    mem_wdata_d = 32'h0000_0000;
    mem_bmask_d = 4'b0000;
    mem_wren_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dec.err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0000_0000;
          end else begin
            mem_addr_d = {i_req_addr[31:2], 2'b00};
            if (i_req_wren) begin
              mem_wdata_d = st_data[31:0];
              mem_bmask_d = st_mask[3:0];
              mem_wren_d  = 1'b1;
            end
          end
        end
      end
      LO: begin
        if (split_q) begin
          // Next word wraps modulo 2^32
          mem_addr_d = mem_addr_q + 32'd4;
          if (wren_q) begin
            mem_wdata_d = st_hi_q;
            mem_bmask_d = mask_hi_q;
            mem_wren_d  = 1'b1;
          end
        end else if (wren_q) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'h0000_0000;
        end
      end
      HI: begin
        if (wren_q) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'h0000_0000;
        end
      end
      FIN: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = ld_data;
      end
      default: ;
    endcase
  end

  // Output registers, cleared asynchronously so a reset drops any access in flight
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      mem_bmask_q <= 4'b0000;
      mem_wren_q  <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_bmask_q <= mem_bmask_d;
      mem_wren_q  <= mem_wren_d;
    end
  end

  // Request control flags, captured at accept
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wren_q  <= 1'b0;
      split_q <= 1'b0;
    end else if (accept) begin
      wren_q  <= i_req_wren;
      split_q <= split_req;
    end
  end

  // Request data and the low load word; no reset needed, only read once qualified
  always_ff @(posedge i_clk) begin
    if (accept) begin
      off_q     <= i_req_addr[1:0];
      f3_q      <= i_req_funct3;
      st_hi_q   <= st_data[63:32];
      mask_hi_q <= st_mask[7:4];
    end
    if (state_q == HI) begin
      lo_word_q <= i_mem_rdata;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for the load/store unit with a small synchronous memory model.
module tb_lsu;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        i_req_wren;
  logic [2:0]  i_req_funct3;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        o_mem_wren;
  logic [31:0] i_mem_rdata;

  int checks   = 0;
  int failures = 0;

  lsu dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .i_req_wren   (i_req_wren),
    .i_req_funct3 (i_req_funct3),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_rsp_err    (o_rsp_err),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_bmask  (o_mem_bmask),
    .o_mem_wren   (o_mem_wren),
    .i_mem_rdata  (i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  // 256-word memory; the addresses used never alias within addr[9:2]
  logic [31:0] mem [0:255];
  always @(posedge i_clk) begin
    i_mem_rdata <= mem[o_mem_addr[9:2]];
    if (o_mem_wren) begin
      for (int b = 0; b < 4; b++) begin
        if (o_mem_bmask[b]) mem[o_mem_addr[9:2]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
      end
    end
  end

  // Present a request at a falling edge, let it be accepted, scramble the
  // request inputs, and return at the falling edge of cycle T+1.
  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input logic w, input logic [2:0] f);
    i_req_valid  = 1'b1;
    i_req_addr   = a;
    i_req_wdata  = d;
    i_req_wren   = w;
    i_req_funct3 = f;
    @(posedge i_clk);
    #1;
    i_req_valid  = 1'b0;
    i_req_addr   = 32'h5555_5555;
    i_req_wdata  = 32'hAAAA_AAAA;
    i_req_wren   = ~w;
    i_req_funct3 = 3'b111;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_req_valid = 1'b0; i_req_addr = '0; i_req_wdata = '0;
    i_req_wren = 1'b0; i_req_funct3 = 3'b000;
    repeat (2) @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", o_rsp_valid); end
    checks++; if (o_rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rsp_rdata got=%h exp=0", o_rsp_rdata); end
    checks++; if (o_rsp_err !== 1'b0) begin failures++; $display("FAIL rst_rsp_err got=%b exp=0", o_rsp_err); end
    checks++; if (o_mem_addr !== 32'h0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", o_mem_addr); end
    checks++; if (o_mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem_wdata got=%h exp=0", o_mem_wdata); end
    checks++; if (o_mem_bmask !== 4'h0) begin failures++; $display("FAIL rst_mem_bmask got=%b exp=0000", o_mem_bmask); end
    checks++; if (o_mem_wren !== 1'b0) begin failures++; $display("FAIL rst_mem_wren got=%b exp=0", o_mem_wren); end
    checks++; if (o_req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", o_req_ready); end
    i_reset = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_word_back_to_back();
    issue(32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 3'b010);
    checks++; if (o_mem_addr !== 32'h100) begin failures++; $display("FAIL sw_addr got=%h exp=00000100", o_mem_addr); end
    checks++; if (o_mem_bmask !== 4'b1111) begin failures++; $display("FAIL sw_bmask got=%b exp=1111", o_mem_bmask); end
    checks++; if (o_mem_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sw_wdata got=%h exp=deadbeef", o_mem_wdata); end
    checks++; if (o_mem_wren !== 1'b1) begin failures++; $display("FAIL sw_wren got=%b exp=1", o_mem_wren); end
    checks++; if (o_rsp_valid !== 1'b0) begin failures++; $display("FAIL sw_early_rsp got=%b exp=0", o_rsp_valid); end
    checks++; if (o_req_ready !== 1'b0) begin failures++; $display("FAIL sw_busy_ready got=%b exp=0", o_req_ready); end
    @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b1) begin failures++; $display("FAIL sw_rsp_valid got=%b exp=1", o_rsp_valid); end
    checks++; if (o_rsp_err !== 1'b0) begin failures++; $display("FAIL sw_rsp_err got=%b exp=0", o_rsp_err); end
    checks++; if (o_mem_wren !== 1'b0) begin failures++; $display("FAIL sw_idle_wren got=%b exp=0", o_mem_wren); end
    checks++; if (o_req_ready !== 1'b1) begin failures++; $display("FAIL sw_rsp_ready got=%b exp=1", o_req_ready); end
    // Accept the load in the same cycle as the store response
    issue(32'h0000_0100, 32'h0, 1'b0, 3'b010);
    checks++; if (o_mem_addr !== 32'h100) begin failures++; $display("FAIL lw_addr got=%h exp=00000100", o_mem_addr); end
    checks++; if (o_mem_wren !== 1'b0 || o_mem_bmask !== 4'b0000) begin failures++; $display("FAIL lw_no_write got=%b/%b exp=0/0000", o_mem_wren, o_mem_bmask); end
    @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b0) begin failures++; $display("FAIL lw_early_rsp got=%b exp=0", o_rsp_valid); end
    @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b1) begin failures++; $display("FAIL lw_rsp_valid got=%b exp=1", o_rsp_valid); end
    checks++; if (o_rsp_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_rdata got=%h exp=deadbeef", o_rsp_rdata); end
  endtask

  task automatic test_byte();
    issue(32'h0000_0103, 32'h0000_00A5, 1'b1, 3'b000);
    checks++; if (o_mem_addr !== 32'h100) begin failures++; $display("FAIL sb_addr got=%h exp=00000100", o_mem_addr); end
    checks++; if (o_mem_bmask !== 4'b1000) begin failures++; $display("FAIL sb_bmask got=%b exp=1000", o_mem_bmask); end
    checks++; if (o_mem_wdata !== 32'hA500_0000) begin failures++; $display("FAIL sb_wdata got=%h exp=a5000000", o_mem_wdata); end
    @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b1) begin failures++; $display("FAIL sb_rsp_valid got=%b exp=1", o_rsp_valid); end
    issue(32'h0000_0103, 32'h0, 1'b0, 3'b000);
    repeat (2) @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 32'hFFFF_FFA5) begin failures++; $display("FAIL lb_rdata got=%b/%h exp=1/ffffffa5", o_rsp_valid, o_rsp_rdata); end
    issue(32'h0000_0103, 32'h0, 1'b0, 3'b100);
    repeat (2) @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 32'h0000_00A5) begin failures++; $display("FAIL lbu_rdata got=%b/%h exp=1/000000a5", o_rsp_valid, o_rsp_rdata); end
  endtask

  task automatic test_split();
    issue(32'h0000_0202, 32'h1122_3344, 1'b1, 3'b010);
    checks++; if (o_mem_addr !== 32'h200 || o_mem_bmask !== 4'b1100 || o_mem_wdata !== 32'h3344_0000 || o_mem_wren !== 1'b1)
      begin failures++; $display("FAIL ssw_lo got=%h/%b/%h/%b exp=00000200/1100/33440000/1", o_mem_addr, o_mem_bmask, o_mem_wdata, o_mem_wren); end
    @(negedge i_clk);
    checks++; if (o_mem_addr !== 32'h204 || o_mem_bmask !== 4'b0011 || o_mem_wdata !== 32'h0000_1122 || o_mem_wren !== 1'b1)
      begin failures++; $display("FAIL ssw_hi got=%h/%b/%h/%b exp=00000204/0011/00001122/1", o_mem_addr, o_mem_bmask, o_mem_wdata, o_mem_wren); end
    checks++; if (o_rsp_valid !== 1'b0) begin failures++; $display("FAIL ssw_early_rsp got=%b exp=0", o_rsp_valid); end
    @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b1) begin failures++; $display("FAIL ssw_rsp_valid got=%b exp=1", o_rsp_valid); end
    issue(32'h0000_0202, 32'h0, 1'b0, 3'b010);
    @(negedge i_clk);
    checks++; if (o_mem_addr !== 32'h204 || o_mem_wren !== 1'b0) begin failures++; $display("FAIL slw_hi got=%h/%b exp=00000204/0", o_mem_addr, o_mem_wren); end
    @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b0) begin failures++; $display("FAIL slw_early_rsp got=%b exp=0", o_rsp_valid); end
    @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 32'h1122_3344) begin failures++; $display("FAIL slw_rdata got=%b/%h exp=1/11223344", o_rsp_valid, o_rsp_rdata); end
    issue(32'h0000_0203, 32'h0, 1'b0, 3'b001);
    repeat (3) @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 32'h0000_2233) begin failures++; $display("FAIL slh_rdata got=%b/%h exp=1/00002233", o_rsp_valid, o_rsp_rdata); end
  endtask

  task automatic test_wrap();
    issue(32'hFFFF_FFFF, 32'h0000_8001, 1'b1, 3'b001);
    checks++; if (o_mem_addr !== 32'hFFFF_FFFC || o_mem_bmask !== 4'b1000 || o_mem_wdata !== 32'h0100_0000)
      begin failures++; $display("FAIL wsh_lo got=%h/%b/%h exp=fffffffc/1000/01000000", o_mem_addr, o_mem_bmask, o_mem_wdata); end
    @(negedge i_clk);
    checks++; if (o_mem_addr !== 32'h0 || o_mem_bmask !== 4'b0001 || o_mem_wdata !== 32'h0000_0080 || o_mem_wren !== 1'b1)
      begin failures++; $display("FAIL wsh_hi got=%h/%b/%h/%b exp=00000000/0001/00000080/1", o_mem_addr, o_mem_bmask, o_mem_wdata, o_mem_wren); end
    @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b1) begin failures++; $display("FAIL wsh_rsp_valid got=%b exp=1", o_rsp_valid); end
    issue(32'hFFFF_FFFF, 32'h0, 1'b0, 3'b001);
    repeat (3) @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 32'hFFFF_8001) begin failures++; $display("FAIL wlh_rdata got=%b/%h exp=1/ffff8001", o_rsp_valid, o_rsp_rdata); end
  endtask

  task automatic test_illegal();
    issue(32'h0000_0100, 32'h1234_5678, 1'b1, 3'b011);
    checks++; if (o_rsp_valid !== 1'b1 || o_rsp_err !== 1'b1 || o_rsp_rdata !== 32'h0)
      begin failures++; $display("FAIL ill_st_rsp got=%b/%b/%h exp=1/1/00000000", o_rsp_valid, o_rsp_err, o_rsp_rdata); end
    checks++; if (o_mem_wren !== 1'b0 || o_mem_addr !== 32'h0) begin failures++; $display("FAIL ill_st_mem got=%b/%h exp=0/00000000", o_mem_wren, o_mem_addr); end
    checks++; if (o_req_ready !== 1'b1) begin failures++; $display("FAIL ill_st_ready got=%b exp=1", o_req_ready); end
    @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b0 || o_rsp_err !== 1'b1) begin failures++; $display("FAIL ill_hold got=%b/%b exp=0/1", o_rsp_valid, o_rsp_err); end
    checks++; if (o_mem_wren !== 1'b0) begin failures++; $display("FAIL ill_st_wren2 got=%b exp=0", o_mem_wren); end
    // BU encoding is load-only
    issue(32'h0000_0100, 32'h1234_5678, 1'b1, 3'b100);
    checks++; if (o_rsp_valid !== 1'b1 || o_rsp_err !== 1'b1 || o_mem_wren !== 1'b0) begin failures++; $display("FAIL ill_sbu got=%b/%b/%b exp=1/1/0", o_rsp_valid, o_rsp_err, o_mem_wren); end
    issue(32'h0000_0100, 32'h0, 1'b0, 3'b110);
    checks++; if (o_rsp_valid !== 1'b1 || o_rsp_err !== 1'b1 || o_rsp_rdata !== 32'h0) begin failures++; $display("FAIL ill_ld got=%b/%b/%h exp=1/1/00000000", o_rsp_valid, o_rsp_err, o_rsp_rdata); end
    issue(32'h0000_0100, 32'h0, 1'b0, 3'b010);
    repeat (2) @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b1 || o_rsp_err !== 1'b0 || o_rsp_rdata !== 32'hA5AD_BEEF)
      begin failures++; $display("FAIL post_ill_lw got=%b/%b/%h exp=1/0/a5adbeef", o_rsp_valid, o_rsp_err, o_rsp_rdata); end
  endtask

  task automatic test_reset_mid();
    issue(32'h0000_0202, 32'h0, 1'b0, 3'b010);
    @(negedge i_clk);
    checks++; if (o_mem_addr !== 32'h204) begin failures++; $display("FAIL rm_hi_addr got=%h exp=00000204", o_mem_addr); end
    i_reset = 1'b1;
    #1;
    checks++; if (o_rsp_valid !== 1'b0 || o_rsp_rdata !== 32'h0 || o_rsp_err !== 1'b0)
      begin failures++; $display("FAIL rm_rsp_clear got=%b/%h/%b exp=0/00000000/0", o_rsp_valid, o_rsp_rdata, o_rsp_err); end
    checks++; if (o_mem_addr !== 32'h0 || o_mem_wdata !== 32'h0 || o_mem_bmask !== 4'b0000 || o_mem_wren !== 1'b0)
      begin failures++; $display("FAIL rm_mem_clear got=%h/%h/%b/%b exp=0/0/0000/0", o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren); end
    @(negedge i_clk);
    i_reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      checks++; if (o_rsp_valid !== 1'b0) begin failures++; $display("FAIL rm_stray_rsp cycle=%0d got=%b exp=0", c, o_rsp_valid); end
    end
    checks++; if (o_req_ready !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b exp=1", o_req_ready); end
    issue(32'h0000_0202, 32'h0, 1'b0, 3'b010);
    repeat (3) @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 32'h1122_3344) begin failures++; $display("FAIL rm_new_lw got=%b/%h exp=1/11223344", o_rsp_valid, o_rsp_rdata); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word_back_to_back();
    test_byte();
    test_split();
    test_wrap();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit: the initiator side of the data-memory port. Accepts one load or store per handshake from the execute stage and sizes it by RISC-V funct3. Drives word-aligned, byte-masked accesses into the data memory and returns aligned, extended load data. Accesses that cross a word boundary are split into two memory cycles; wrap-around past 0xFFFF_FFFF is modular.

## Interface
- No parameters; data and address widths are fixed at 32.
- i_clk  in  1  clock; all state on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  high only in IDLE; accept = valid & ready
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  store data, LSB-aligned
- i_req_wren  in  1  1 = store, 0 = load
- i_req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- o_rsp_valid  out  1  one-cycle completion pulse
- o_rsp_rdata  out  32  load result; 0 for stores and errors
- o_rsp_err  out  1  illegal funct3; qualified by o_rsp_valid
- o_mem_addr  out  32  word address (bits [1:0] = 0)
- o_mem_wdata  out  32  lane-positioned store data
- o_mem_bmask  out  4  byte-lane write enables
- o_mem_wren  out  1  write strobe
- i_mem_rdata  in  32  read data for the address driven in the previous cycle

## Operation
- Memory contract: synchronous read, 1 cycle latency. A write is committed at the edge ending the cycle in which o_mem_wren = 1, with lanes gated by bmask.
- Size: s = 1/2/4 bytes from funct3[1:0]. Offset o = addr[1:0]. The access is split when o + s > 4.
- Legal encodings: loads 000, 001, 010, 100, 101; stores 000, 001, 010. Anything else is an error: no memory cycle, response on the next cycle with err = 1 and rdata = 0.
- States:
  - IDLE: ready = 1; on accept, latch the request and go to LO.
  - LO: drive {addr[31:2], 2'b00}. Next state is HI if split, else FIN for a load; a non-split store goes to IDLE.
  - HI: drive low word + 4 (mod 2^32). For a load, capture i_mem_rdata as the low word. Next state is FIN for a load, IDLE for a store.
  - FIN: capture the final word and register the result. Go to IDLE.
- Store lanes: the 8-bit mask is ((1<<s)-1) << o, and the 64-bit data is wdata << 8·o. The low half goes out in LO and the high half in HI.
- Load result: ({hi, lo} >> 8·o), truncated to s bytes. Sign-extend for B/H, zero-extend for BU/HU.
- Memory outputs are all 0 (wren = 0, bmask = 0) in IDLE and FIN, and in LO/HI when the access is a load.
- o_rsp_valid / o_rsp_rdata / o_rsp_err are registered. rdata and err hold their value until the next response.
- Reset (asynchronous, any state): state = IDLE, and every output register is 0: rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_bmask, mem_wren.
- Reset mid-store: the LO half may already be committed. This partial write is accepted behaviour, and no response is issued.

## Timing
- Accept at cycle T. o_rsp_valid is asserted at:
  - T+1: error.
  - T+2: aligned store.
  - T+3: split store, or aligned load.
  - T+4: split load.
- The response cycle is IDLE with ready = 1, so back-to-back accept is allowed in that cycle.
- Request inputs are sampled only at accept; changes afterwards are ignored.

## Structure
- lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - the state enum (IDLE, LO, HI, FIN)
  - a size/legality decode function
- Sub-module lsu_align is purely combinational and contains the store shift/mask generation and the load shift/extend. The FSM and registers stay in lsu.

## Test plan
- SW 0x100 data 0xDEADBEEF:
  - T+1: addr 0x100, bmask 1111, wren 1.
  - T+2: rsp_valid with err 0.
  - Follow with LW 0x100, which returns 0xDEADBEEF at T+3.
- SB 0x103 data 0xA5:
  - Memory cycle: bmask 1000, wdata 0xA500_0000.
  - LB 0x103 returns 0xFFFF_FFA5; LBU 0x103 returns 0x0000_00A5.
- SW 0x202 data 0x1122_3344 (split):
  - LO: addr 0x200, bmask 1100, wdata 0x3344_0000.
  - HI: addr 0x204, bmask 0011, wdata 0x0000_1122.
  - LW 0x202 returns 0x1122_3344 at T+4; LH 0x203 returns 0x0000_2233.
- SH 0xFFFF_FFFF data 0x8001 (wrap):
  - LO: addr 0xFFFF_FFFC, bmask 1000, wdata 0x0100_0000.
  - HI: addr 0x0000_0000, bmask 0001, wdata 0x0000_0080.
  - LH 0xFFFF_FFFF returns 0xFFFF_8001.
- Store with funct3 011: rsp at T+1 with err 1 and rdata 0; o_mem_wren never asserted.
- Reset pulse during HI of a split LW:
  - All outputs go to 0 immediately.
  - No rsp_valid after release.
  - ready = 1, and a new LW completes normally.
